// File: rtl/kbd_mouse_decoder.sv
// Decodes a toggle-signalled event stream into mouse position counters and a FWFT
// keyboard scancode FIFO, tracking the Ctrl+LAmiga+RAmiga reset chord.
module kbd_mouse_decoder #(
  parameter int unsigned FIFO_AW = 3
) (
  input  logic             clk_sys,
  input  logic             reset_n,
  input  logic             kbd_mouse_level,
  input  logic [1:0]       kbd_mouse_type,
  input  logic [7:0]       kbd_mouse_data,
  output logic [7:0]       mouse_x,
  output logic [7:0]       mouse_y,
  output logic [7:0]       kbd_data,
  output logic             kbd_valid,
  input  logic             kbd_ack,
  output logic [FIFO_AW:0] kbd_count,
  output logic             kbd_overflow,
  output logic             kbd_reset
);

  localparam int unsigned Depth = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0] DepthCnt = (FIFO_AW + 1)'(Depth);

  localparam logic [1:0] TypeMouseX = 2'd0;
  localparam logic [1:0] TypeMouseY = 2'd1;
  localparam logic [1:0] TypeKbd    = 2'd2;

  logic               level_q, level_d;
  logic               armed_q, armed_d;
  logic [7:0]         mouse_x_q, mouse_x_d;
  logic [7:0]         mouse_y_q, mouse_y_d;
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               overflow_q, overflow_d;
  logic               ctrl_q, ctrl_d;
  logic               lami_q, lami_d;
  logic               rami_q, rami_d;
  logic               kbd_reset_q, kbd_reset_d;

  logic [7:0] mem [Depth];

  logic evt;
  logic kbd_evt;
  logic push;
  logic pop;
  logic full;
  logic accept;

  always_comb begin
    evt     = armed_q & (kbd_mouse_level != level_q);
    kbd_evt = evt & (kbd_mouse_type == TypeKbd);
    push    = kbd_evt;
    pop     = (count_q != '0) & kbd_ack;
    full    = (count_q == DepthCnt);
    // A simultaneous pop frees the head slot, so a push to a full FIFO still fits.
    accept  = push & (~full | pop);
  end

  always_comb begin
    armed_d   = 1'b1;
    level_d   = kbd_mouse_level;
    mouse_x_d = mouse_x_q;
    mouse_y_d = mouse_y_q;
    if (evt && kbd_mouse_type == TypeMouseX) begin
      mouse_x_d = mouse_x_q + kbd_mouse_data;
    end
    if (evt && kbd_mouse_type == TypeMouseY) begin
      mouse_y_d = mouse_y_q + kbd_mouse_data;
    end
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (accept) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (accept && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!accept && pop) begin
      count_d = count_q - 1'b1;
    end
    if (push && !accept) begin
      overflow_d = 1'b1;
    end
  end

  // Chord tracking sees every keyboard event, including codes the FIFO dropped.
  always_comb begin
    ctrl_d = ctrl_q;
    lami_d = lami_q;
    rami_d = rami_q;
    if (kbd_evt) begin
      case (kbd_mouse_data)
        8'h63:   ctrl_d = 1'b1;
        8'hE3:   ctrl_d = 1'b0;
        8'h66:   lami_d = 1'b1;
        8'hE6:   lami_d = 1'b0;
        8'h67:   rami_d = 1'b1;
        8'hE7:   rami_d = 1'b0;
        default: ;
      endcase
    end
    kbd_reset_d = ctrl_d & lami_d & rami_d;
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      level_q     <= 1'b0;
      armed_q     <= 1'b0;
      mouse_x_q   <= '0;
      mouse_y_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      ctrl_q      <= 1'b0;
      lami_q      <= 1'b0;
      rami_q      <= 1'b0;
      kbd_reset_q <= 1'b0;
    end else begin
      level_q     <= level_d;
      armed_q     <= armed_d;
      mouse_x_q   <= mouse_x_d;
      mouse_y_q   <= mouse_y_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      ctrl_q      <= ctrl_d;
      lami_q      <= lami_d;
      rami_q      <= rami_d;
      kbd_reset_q <= kbd_reset_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (accept) begin
      mem[wr_ptr_q] <= kbd_mouse_data;
    end
  end

  assign mouse_x      = mouse_x_q;
  assign mouse_y      = mouse_y_q;
  assign kbd_data     = mem[rd_ptr_q];
  assign kbd_valid    = (count_q != '0);
  assign kbd_count    = count_q;
  assign kbd_overflow = overflow_q;
  assign kbd_reset    = kbd_reset_q;

endmodule
